digit_string_matcher: RTL and testbench

//  Parametrised successor of the single-digit string finder. Buffers up to MAX_LEN
//  BCD-style digits typed by the user and searches them for a PAT_LEN-digit pattern.

---
 rtl/digit_string_matcher.sv | 181 ++++++++++++++++++
 tb/tb_digit_string_matcher.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_string_matcher.sv
// Digit string buffer with PAT_LEN-digit pattern search and blinking replay.
// Define MATCH_OVERLAP_EN to count overlapping matches during the scan.
module digit_string_matcher #(
  parameter int DIGIT_W     = 4,
  parameter int MAX_LEN     = 10,
  parameter int PAT_LEN     = 2,
  parameter int MATCH_DEPTH = 16,
  parameter int HALF_TICKS  = 100_000_000,
  localparam int POS_W = $clog2(MAX_LEN+1),
  localparam int CNT_W = $clog2(MATCH_DEPTH+1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DIGIT_W-1:0]         in_digit,
  input  logic                       push,
  input  logic                       del,
  input  logic                       done,
  input  logic                       roll_back,
  input  logic [PAT_LEN*DIGIT_W-1:0] pattern,
  output logic [POS_W-1:0]           str_len,
  output logic                       full,
  output logic [POS_W-1:0]           live_hit_pos,
  output logic [CNT_W-1:0]           match_count,
  output logic                       match_ovf,
  output logic                       scan_done,
  output logic [POS_W-1:0]           show_pos,
  output logic                       show_on
);
  localparam int PW    = PAT_LEN*DIGIT_W;
  localparam int IDX_W = (MATCH_DEPTH > 1) ? $clog2(MATCH_DEPTH) : 1;
  localparam int BLK_W = $clog2(2*HALF_TICKS);

  typedef enum logic [1:0] {ENTRY, SCAN, SHOW} state_t;
  state_t state, state_nx;

  logic [DIGIT_W-1:0] str     [MAX_LEN];
  logic [DIGIT_W-1:0] nxt_str [MAX_LEN];
  logic [POS_W-1:0]   tbl     [MATCH_DEPTH];
  logic [PW-1:0]      pat_q;
  logic [POS_W-1:0]   scan_i;
  logic [POS_W-1:0]   len_inc;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [BLK_W-1:0]   blink;
  logic [CNT_W-1:0]   cnt_m1;
  logic               push_ok, del_ok, live_hit;
  logic               scan_in, scan_hit, has_hits;
  logic [POS_W-1:0]   step;

  function automatic logic win_eq(
    input logic [DIGIT_W-1:0] s [MAX_LEN],
    input int                 st,
    input logic [PW-1:0]      pat
  );
    logic eq;
    eq = 1'b1;
    for (int k = 0; k < PAT_LEN; k++) begin
      if (st + k >= MAX_LEN) eq = 1'b0;
      for (int j = 0; j < MAX_LEN; j++)
        if (j == st + k && s[j] != pat[k*DIGIT_W +: DIGIT_W])
          eq = 1'b0;
    end
    return eq;
  endfunction

  assign full      = (str_len == POS_W'(MAX_LEN));
  assign scan_done = (state == SHOW);
  assign del_ok    = del && (str_len != '0);
  assign push_ok   = push && !del && !full;
  assign len_inc   = str_len + POS_W'(1);
  assign has_hits  = (match_count != '0);
  assign cnt_m1    = match_count - CNT_W'(1);
  assign idx_nx    = (CNT_W'(idx) == cnt_m1) ? '0 : idx + IDX_W'(1);
  assign scan_in   = (int'(scan_i) + PAT_LEN <= int'(str_len));

  // string as it will look after this cycle's edit
  always_comb begin
    for (int j = 0; j < MAX_LEN; j++) begin
      nxt_str[j] = str[j];
      if (push_ok && j == int'(str_len))
        nxt_str[j] = in_digit;
      if (del_ok && j == int'(str_len) - 1)
        nxt_str[j] = '0;
    end
  end

  always_comb begin
    live_hit = 1'b0;
    if (push_ok && int'(len_inc) >= PAT_LEN)
      live_hit = win_eq(nxt_str, int'(len_inc) - PAT_LEN, pattern);
    scan_hit = scan_in && win_eq(str, int'(scan_i), pat_q);
`ifdef MATCH_OVERLAP_EN
    step = POS_W'(1);
`else
    step = scan_hit ? POS_W'(PAT_LEN) : POS_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ENTRY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ENTRY:
        if (done || (push_ok && len_inc == POS_W'(MAX_LEN)))
          state_nx = SCAN;
      SCAN:
        if (!scan_in) state_nx = SHOW;
      SHOW:    state_nx = SHOW;
      default: state_nx = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < MAX_LEN; j++) str[j] <= '0;
      for (int j = 0; j < MATCH_DEPTH; j++) tbl[j] <= '0;
      str_len      <= '0;
      live_hit_pos <= '0;
      match_count  <= '0;
      match_ovf    <= 1'b0;
      show_pos     <= '0;
      show_on      <= 1'b0;
      pat_q        <= '0;
      scan_i       <= '0;
      idx          <= '0;
      blink        <= '0;
    end else begin
      unique case (state)
        ENTRY: begin
          str <= nxt_str;
          if (del_ok)       str_len <= str_len - POS_W'(1);
          else if (push_ok) str_len <= len_inc;
          if (live_hit)
            live_hit_pos <= len_inc - POS_W'(PAT_LEN-1);
          if (state_nx == SCAN) pat_q <= pattern;
          scan_i <= '0;
        end
        SCAN: begin
          if (scan_in) begin
            scan_i <= scan_i + step;
            if (scan_hit) begin
              if (match_count != CNT_W'(MATCH_DEPTH)) begin
                tbl[match_count[IDX_W-1:0]] <= scan_i + POS_W'(1);
                match_count <= match_count + CNT_W'(1);
              end else begin
                match_ovf <= 1'b1;
              end
            end
          end else begin
            idx      <= '0;
            blink    <= '0;
            show_on  <= has_hits;
            show_pos <= has_hits ? tbl[0] : '0;
          end
        end
        SHOW: begin
          if (has_hits) begin
            if (roll_back) begin
              idx      <= '0;
              blink    <= '0;
              show_on  <= 1'b1;
              show_pos <= tbl[0];
            end else if (blink == BLK_W'(2*HALF_TICKS-1)) begin
              idx      <= idx_nx;
              blink    <= '0;
              show_on  <= 1'b1;
              show_pos <= tbl[idx_nx];
            end else begin
              blink   <= blink + BLK_W'(1);
              show_on <= (int'(blink) + 1 < HALF_TICKS);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_digit_string_matcher.sv
// Bench for digit_string_matcher: queue-based reference model plus directed cases.
module tb_digit_string_matcher;
  localparam int DW = 4;
  localparam int ML = 10;
  localparam int PL = 2;
  localparam int MD = 4;
  localparam int HT = 4;
  localparam int POS_W = $clog2(ML+1);
  localparam int CNT_W = $clog2(MD+1);

  logic clk = 1'b0;
  logic reset;
  logic [DW-1:0] in_digit;
  logic push, del, done, roll_back;
  logic [PL*DW-1:0] pattern;
  logic [POS_W-1:0] str_len, live_hit_pos, show_pos;
  logic [CNT_W-1:0] match_count;
  logic full, match_ovf, scan_done, show_on;

  digit_string_matcher #(
    .DIGIT_W(DW), .MAX_LEN(ML), .PAT_LEN(PL),
    .MATCH_DEPTH(MD), .HALF_TICKS(HT)
  ) dut (
    .clk(clk), .reset(reset), .in_digit(in_digit),
    .push(push), .del(del), .done(done),
    .roll_back(roll_back), .pattern(pattern),
    .str_len(str_len), .full(full),
    .live_hit_pos(live_hit_pos),
    .match_count(match_count), .match_ovf(match_ovf),
    .scan_done(scan_done), .show_pos(show_pos),
    .show_on(show_on)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: 0=entry 1=scan 2=show
  int mst;
  int q[$];
  int mtab[$];
  int lhp, scan_left, t;
  logic [PL*DW-1:0] pat_l;
  bit dok, pok, hit;

  function automatic void do_scan();
    int i, w;
    bit h;
    mtab.delete();
    i = 0;
    w = 0;
    while (i + PL <= q.size()) begin
      w++;
      h = 1;
      for (int k = 0; k < PL; k++)
        if (q[i+k] != int'(pat_l[k*DW +: DW])) h = 0;
      if (h) begin
        mtab.push_back(i + 1);
`ifdef MATCH_OVERLAP_EN
        i += 1;
`else
        i += PL;
`endif
      end else begin
        i += 1;
      end
    end
    scan_left = w + 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mst = 0; q.delete(); mtab.delete();
      lhp = 0; scan_left = 0; t = 0;
    end else begin
      case (mst)
        0: begin
          dok = del && q.size() > 0;
          pok = push && !del && q.size() < ML;
          if (dok) void'(q.pop_back());
          else if (pok) q.push_back(int'(in_digit));
          if (pok && q.size() >= PL) begin
            hit = 1;
            for (int k = 0; k < PL; k++)
              if (q[q.size()-PL+k] != int'(pattern[k*DW +: DW])) hit = 0;
            if (hit) lhp = q.size() - PL + 1;
          end
          if (done || (pok && q.size() == ML)) begin
            pat_l = pattern;
            do_scan();
            mst = 1;
          end
        end
        1: begin
          scan_left--;
          if (scan_left == 0) begin
            mst = 2;
            t = 0;
          end
        end
        default: if (roll_back) t = 0; else t++;
      endcase
    end
  end

  always @(negedge clk) begin
    int ms, ep, eo;
    if (cmp_en) begin
      ms = (mtab.size() < MD) ? mtab.size() : MD;
      check("str_len", int'(str_len), q.size());
      check("full", int'(full), int'(q.size() == ML));
      check("live_hit_pos", int'(live_hit_pos), lhp);
      check("scan_done", int'(scan_done), int'(mst == 2));
      ep = 0;
      eo = 0;
      if (mst == 2 && ms > 0) begin
        ep = mtab[(t / (2*HT)) % ms];
        eo = int'((t % (2*HT)) < HT);
      end
      check("show_pos", int'(show_pos), ep);
      check("show_on", int'(show_on), eo);
      if (mst != 1) begin
        check("match_count", int'(match_count), (mst == 2) ? ms : 0);
        check("match_ovf", int'(match_ovf),
              int'(mst == 2 && mtab.size() > MD));
      end
    end
  end

  task automatic strobe(bit p, bit d, bit dn, bit rb, logic [DW-1:0] dig);
    push = p; del = d; done = dn; roll_back = rb; in_digit = dig;
    @(negedge clk);
    push = 0; del = 0; done = 0; roll_back = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_show();
    for (int i = 0; i < 20 && !scan_done; i++) @(negedge clk);
    check("scan_to_show", int'(scan_done), 1);
  endtask

  function automatic logic [PL*DW-1:0] rand_pat();
    return {DW'($urandom_range(0, 2)), DW'($urandom_range(0, 2))};
  endfunction

  initial begin
    int nops, r, n;
    logic [DW-1:0] d;
    reset = 1; push = 0; del = 0; done = 0; roll_back = 0;
    in_digit = '0; pattern = '0;
    @(negedge clk);
    cmp_en = 1;
    reset = 0;
    check("rst_str_len", int'(str_len), 0);
    check("rst_match_count", int'(match_count), 0);

    // case 1: 1,2,3,1,2 with pattern 12
    do_reset();
    pattern = 8'h21;
    strobe(1,0,0,0,1); strobe(1,0,0,0,2); strobe(1,0,0,0,3);
    strobe(1,0,0,0,1); strobe(1,0,0,0,2);
    check("c1_live", int'(live_hit_pos), 4);
    strobe(0,0,1,0,0);
    wait_show();
    check("c1_count", int'(match_count), 2);
    check("c1_pos0", int'(show_pos), 1);
    check("c1_on0", int'(show_on), 1);
    wait_n(4);
    check("c1_off", int'(show_on), 0);
    check("c1_pos_off", int'(show_pos), 1);
    wait_n(4);
    check("c1_pos1", int'(show_pos), 4);
    check("c1_on1", int'(show_on), 1);
    strobe(0,0,0,1,0);
    check("c6_rb_pos", int'(show_pos), 1);
    check("c6_rb_on", int'(show_on), 1);
    do_reset();
    check("c6_show_rst_done", int'(scan_done), 0);
    check("c6_show_rst_len", int'(str_len), 0);

    // case 2: 1,1,1,1 with pattern 11
    pattern = 8'h11;
    repeat (4) strobe(1,0,0,0,1);
    strobe(0,0,1,0,0);
    wait_show();
`ifdef MATCH_OVERLAP_EN
    check("c2_count", int'(match_count), 3);
    wait_n(8);
    check("c2_pos1", int'(show_pos), 2);
`else
    check("c2_count", int'(match_count), 2);
    wait_n(8);
    check("c2_pos1", int'(show_pos), 3);
`endif

    // case 3: edits and live hit
    do_reset();
    pattern = 8'h75;
    strobe(1,0,0,0,5); strobe(1,0,0,0,6);
    strobe(0,1,0,0,0); strobe(1,0,0,0,7);
    check("c3_len", int'(str_len), 2);
    check("c3_live", int'(live_hit_pos), 1);
    strobe(1,1,0,0,4);
    check("c3_pushdel", int'(str_len), 1);

    // case 4: fill to MAX_LEN with zeros
    do_reset();
    pattern = 8'h00;
    repeat (ML) strobe(1,0,0,0,0);
    check("c4_full", int'(full), 1);
    strobe(1,0,0,0,0);
    check("c4_len", int'(str_len), ML);
    wait_show();
    check("c4_count", int'(match_count), MD);
    check("c4_ovf", int'(match_ovf), 1);

    // case 5: too short for any window
    do_reset();
    pattern = 8'h33;
    strobe(1,0,0,0,3);
    strobe(0,0,1,0,0);
    check("c5_in_scan", int'(scan_done), 0);
    @(negedge clk);
    check("c5_show", int'(scan_done), 1);
    wait_n(6);
    check("c5_on", int'(show_on), 0);

    // case 6: reset mid-scan
    do_reset();
    pattern = 8'h11;
    repeat (6) strobe(1,0,0,0,1);
    strobe(0,0,1,0,0);
    @(negedge clk);
    do_reset();
    check("c6_scan_rst_len", int'(str_len), 0);
    check("c6_scan_rst_cnt", int'(match_count), 0);
    check("c6_scan_rst_live", int'(live_hit_pos), 0);

    for (int it = 0; it < 150; it++) begin
      do_reset();
      pattern = rand_pat();
      nops = $urandom_range(0, 14);
      for (int o = 0; o < nops; o++) begin
        r = $urandom_range(0, 99);
        d = DW'($urandom_range(0, 2));
        if (r < 55)      strobe(1,0,0,0,d);
        else if (r < 70) strobe(0,1,0,0,d);
        else if (r < 78) strobe(1,1,0,0,d);
        else if (r < 82) strobe(1,0,1,0,d);
        else             strobe(0,0,0,0,d);
        if ($urandom_range(0, 9) == 0) pattern = rand_pat();
      end
      strobe(0,0,1,0,0);
      n = $urandom_range(0, 50);
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(0, 19) == 0) pattern = rand_pat();
        strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
               DW'($urandom_range(0, 2)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
